id_ex_register: RTL and testbench

Pipeline register between decode and execute in the 5-stage RISC-V core. Captures the 10 decoded control bits and the decode-stage operands each cycle. Detects load-use hazards against the instruction currently in EX, and stalls fetch/decode while injecting a bubble. Applies a flush when a taken branch or jump resolves downstream.

---
 rtl/pipeline_pkg.sv | 38 +++
 rtl/load_use_detector.sv | 24 ++
 rtl/id_ex_register.sv | 113 +++++++++++
 tb/tb_id_ex_register.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: ALU_Op instruction classes, the ID/EX control bundle
// and the source-usage decode shared by hazard detection and forwarding.
package pipeline_pkg;

  localparam logic [2:0] R_TYPE      = 3'b000;
  localparam logic [2:0] I_TYPE      = 3'b001;
  localparam logic [2:0] LOAD_TYPE   = 3'b010;
  localparam logic [2:0] JALR_TYPE   = 3'b011;
  localparam logic [2:0] STORE_TYPE  = 3'b100;
  localparam logic [2:0] BRANCH_TYPE = 3'b101;
  localparam logic [2:0] JAL_TYPE    = 3'b110;
  localparam logic [2:0] U_TYPE      = 3'b111;

  localparam int CTRL_WIDTH = 10;

  typedef struct packed {
    logic       jalr;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [2:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // JAL and LUI carry no register sources; everything below them reads rs1.
  function automatic logic rs1_used(input logic [2:0] alu_op);
    return alu_op <= BRANCH_TYPE;
  endfunction

  function automatic logic rs2_used(input logic [2:0] alu_op);
    return (alu_op == R_TYPE) || (alu_op == STORE_TYPE) || (alu_op == BRANCH_TYPE);
  endfunction

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard check of the ID instruction against a load in EX.
module load_use_detector
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] rd,
  input  logic [REG_ADDR_WIDTH-1:0] rs1,
  input  logic [REG_ADDR_WIDTH-1:0] rs2,
  input  logic [2:0]                alu_op,
  output logic                      hazard
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = rs1_used(alu_op) && (rs1 == rd);
  assign rs2_hit = rs2_used(alu_op) && (rs2 == rd);

  // x0 is hard-wired zero, so a load targeting it never produces a dependency.
  assign hazard = mem_read && (rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register: captures decode controls and operands, injects a bubble
// on flush or load-use hazard, and stalls fetch/decode for the hazard cycle.
module id_ex_register
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush_i,
  input  logic                      jalr_i,
  input  logic                      branch_i,
  input  logic                      mem_read_i,
  input  logic                      mem_to_reg_i,
  input  logic                      mem_write_i,
  input  logic                      alu_src_i,
  input  logic                      reg_write_i,
  input  logic [2:0]                alu_op_i,
  input  logic [DATA_WIDTH-1:0]     pc_i,
  input  logic [DATA_WIDTH-1:0]     rs1_data_i,
  input  logic [DATA_WIDTH-1:0]     rs2_data_i,
  input  logic [DATA_WIDTH-1:0]     imm_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_i,
  input  logic [3:0]                funct_i,
  output logic                      jalr_o,
  output logic                      branch_o,
  output logic                      mem_read_o,
  output logic                      mem_to_reg_o,
  output logic                      mem_write_o,
  output logic                      alu_src_o,
  output logic                      reg_write_o,
  output logic [2:0]                alu_op_o,
  output logic [DATA_WIDTH-1:0]     pc_o,
  output logic [DATA_WIDTH-1:0]     rs1_data_o,
  output logic [DATA_WIDTH-1:0]     rs2_data_o,
  output logic [DATA_WIDTH-1:0]     imm_o,
  output logic [REG_ADDR_WIDTH-1:0] rs1_o,
  output logic [REG_ADDR_WIDTH-1:0] rs2_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_o,
  output logic [3:0]                funct_o,
  output logic                      stall_o
);

  typedef struct packed {
    ctrl_t                     ctrl;
    logic [DATA_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     rs1_data;
    logic [DATA_WIDTH-1:0]     rs2_data;
    logic [DATA_WIDTH-1:0]     imm;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [3:0]                funct;
  } stage_t;

  stage_t stage_q;
  stage_t stage_in;
  logic   hazard;

  assign stage_in = '{
    ctrl: '{jalr: jalr_i, branch: branch_i, mem_read: mem_read_i,
            mem_to_reg: mem_to_reg_i, mem_write: mem_write_i,
            alu_src: alu_src_i, reg_write: reg_write_i, alu_op: alu_op_i},
    pc: pc_i, rs1_data: rs1_data_i, rs2_data: rs2_data_i, imm: imm_i,
    rs1: rs1_i, rs2: rs2_i, rd: rd_i, funct: funct_i
  };

  load_use_detector #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_load_use_detector (
    .mem_read (stage_q.ctrl.mem_read),
    .rd       (stage_q.rd),
    .rs1      (rs1_i),
    .rs2      (rs2_i),
    .alu_op   (alu_op_i),
    .hazard   (hazard)
  );

  // A flush overrides the stall so fetch can redirect to the branch target.
  assign stall_o = hazard && !flush_i;

  // The bubble zeroes the whole stage (rd included) so it cannot re-trigger a hazard.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q <= '0;
    end else if (flush_i || hazard) begin
      stage_q <= '{ctrl: CTRL_BUBBLE, default: '0};
    end else begin
      stage_q <= stage_in;
    end
  end

  assign jalr_o       = stage_q.ctrl.jalr;
  assign branch_o     = stage_q.ctrl.branch;
  assign mem_read_o   = stage_q.ctrl.mem_read;
  assign mem_to_reg_o = stage_q.ctrl.mem_to_reg;
  assign mem_write_o  = stage_q.ctrl.mem_write;
  assign alu_src_o    = stage_q.ctrl.alu_src;
  assign reg_write_o  = stage_q.ctrl.reg_write;
  assign alu_op_o     = stage_q.ctrl.alu_op;
  assign pc_o         = stage_q.pc;
  assign rs1_data_o   = stage_q.rs1_data;
  assign rs2_data_o   = stage_q.rs2_data;
  assign imm_o        = stage_q.imm;
  assign rs1_o        = stage_q.rs1;
  assign rs2_o        = stage_q.rs2;
  assign rd_o         = stage_q.rd;
  assign funct_o      = stage_q.funct;

endmodule

// File: tb/tb_id_ex_register.sv
// Scoreboard bench for id_ex_register: directed test-plan cases plus randomized
// traffic checked against a behavioural model of the ID/EX stage.
module tb_id_ex_register;

  typedef struct packed {
    logic        jalr;
    logic        branch;
    logic        mem_read;
    logic        mem_to_reg;
    logic        mem_write;
    logic        alu_src;
    logic        reg_write;
    logic [2:0]  alu_op;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  funct;
  } id_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush_i = 1'b0;
  logic        jalr_i = 1'b0, branch_i = 1'b0, mem_read_i = 1'b0, mem_to_reg_i = 1'b0;
  logic        mem_write_i = 1'b0, alu_src_i = 1'b0, reg_write_i = 1'b0;
  logic [2:0]  alu_op_i = '0;
  logic [31:0] pc_i = '0, rs1_data_i = '0, rs2_data_i = '0, imm_i = '0;
  logic [4:0]  rs1_i = '0, rs2_i = '0, rd_i = '0;
  logic [3:0]  funct_i = '0;
  logic        jalr_o, branch_o, mem_read_o, mem_to_reg_o, mem_write_o, alu_src_o, reg_write_o;
  logic [2:0]  alu_op_o;
  logic [31:0] pc_o, rs1_data_o, rs2_data_o, imm_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [3:0]  funct_o;
  logic        stall_o;

  int tests_run = 0;
  int tests_failed = 0;

  id_t    out_q[$];
  string  out_name_q[$];
  logic   stall_q[$];
  string  stall_name_q[$];
  id_t    model_ex;

  always #5 clk = ~clk;

  id_ex_register #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .jalr_i(jalr_i), .branch_i(branch_i), .mem_read_i(mem_read_i),
    .mem_to_reg_i(mem_to_reg_i), .mem_write_i(mem_write_i), .alu_src_i(alu_src_i),
    .reg_write_i(reg_write_i), .alu_op_i(alu_op_i), .pc_i(pc_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .funct_i(funct_i),
    .jalr_o(jalr_o), .branch_o(branch_o), .mem_read_o(mem_read_o),
    .mem_to_reg_o(mem_to_reg_o), .mem_write_o(mem_write_o), .alu_src_o(alu_src_o),
    .reg_write_o(reg_write_o), .alu_op_o(alu_op_o), .pc_o(pc_o),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .imm_o(imm_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .funct_o(funct_o),
    .stall_o(stall_o)
  );

  function automatic id_t dut_out();
    return {jalr_o, branch_o, mem_read_o, mem_to_reg_o, mem_write_o, alu_src_o,
            reg_write_o, alu_op_o, pc_o, rs1_data_o, rs2_data_o, imm_o,
            rs1_o, rs2_o, rd_o, funct_o};
  endfunction

  task automatic check(input string name, input logic [156:0] act, input logic [156:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference rules: which instruction classes read which sources.
  function automatic bit reads_rs1(input logic [2:0] op);
    return op inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
  endfunction

  function automatic bit reads_rs2(input logic [2:0] op);
    return op inside {3'd0, 3'd4, 3'd5};
  endfunction

  // Present one ID instruction at a falling edge; predict stall now and EX next cycle.
  task automatic drive(input string name, input id_t t, input logic fl);
    bit dep;
    bit haz;
    {jalr_i, branch_i, mem_read_i, mem_to_reg_i, mem_write_i, alu_src_i, reg_write_i,
     alu_op_i, pc_i, rs1_data_i, rs2_data_i, imm_i, rs1_i, rs2_i, rd_i, funct_i} = t;
    flush_i = fl;
    dep = (reads_rs1(t.alu_op) && t.rs1 == model_ex.rd) ||
          (reads_rs2(t.alu_op) && t.rs2 == model_ex.rd);
    haz = model_ex.mem_read && model_ex.rd != 0 && dep;
    stall_q.push_back(haz && !fl);
    stall_name_q.push_back({name, "/stall"});
    model_ex = (fl || haz) ? id_t'(0) : t;
    out_q.push_back(model_ex);
    out_name_q.push_back({name, "/ex"});
    @(negedge clk);
  endtask

  function automatic id_t mk(input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic [31:0] pc, input logic mr,
                             input logic mw, input logic rw);
    id_t t;
    t = '0;
    t.alu_op = op; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.pc = pc;
    t.mem_read = mr; t.mem_to_reg = mr; t.mem_write = mw; t.reg_write = rw;
    t.alu_src = (op != 3'd0); t.rs1_data = 32'h1000 + 32'(rs1); t.rs2_data = 32'h2000 + 32'(rs2);
    t.imm = pc ^ 32'h55; t.funct = 4'(op) ^ 4'h9;
    return t;
  endfunction

  function automatic id_t rand_txn();
    id_t t;
    t = '0;
    t.jalr = 1'($urandom); t.branch = 1'($urandom); t.alu_src = 1'($urandom);
    t.reg_write = 1'($urandom); t.mem_write = 1'($urandom); t.mem_to_reg = 1'($urandom);
    t.mem_read = ($urandom_range(0, 2) == 0);
    t.alu_op = 3'($urandom); t.pc = $urandom; t.rs1_data = $urandom;
    t.rs2_data = $urandom; t.imm = $urandom; t.funct = 4'($urandom);
    t.rs1 = 5'($urandom_range(0, 7)); t.rs2 = 5'($urandom_range(0, 7));
    t.rd = 5'($urandom_range(0, 7));
    return t;
  endfunction

  // Registered outputs are sampled just after the rising edge.
  always @(posedge clk) begin
    #1;
    if (out_q.size() > 0) check(out_name_q.pop_front(), 157'(dut_out()), 157'(out_q.pop_front()));
  end

  // stall_o is sampled during the low phase, after the ID inputs have settled.
  always @(negedge clk) begin
    #2;
    if (stall_q.size() > 0) check(stall_name_q.pop_front(), 157'(stall_o), 157'(stall_q.pop_front()));
  end

  initial begin
    id_t t;
    id_t prev;
    logic fl;
    bit held;
    model_ex = '0;
    prev = '0;
    #3;
    check("reset_outputs", 157'(dut_out()), 157'(0));
    check("reset_stall", 157'(stall_o), 157'(0));
    @(negedge clk);
    reset = 1'b1;

    // Normal capture: R-type rs1=3 rs2=4 rd=5 pc=0x40.
    drive("normal_r", mk(3'd0, 5'd3, 5'd4, 5'd5, 32'h40, 1'b0, 1'b0, 1'b1), 1'b0);
    // Load-use on rs2, then the re-presented R-type is captured.
    drive("load_rd7", mk(3'd2, 5'd1, 5'd0, 5'd7, 32'h44, 1'b1, 1'b0, 1'b1), 1'b0);
    drive("use_rs2_stall", mk(3'd0, 5'd2, 5'd7, 5'd8, 32'h48, 1'b0, 1'b0, 1'b1), 1'b0);
    drive("use_rs2_retry", mk(3'd0, 5'd2, 5'd7, 5'd8, 32'h48, 1'b0, 1'b0, 1'b1), 1'b0);
    // No false hazard: LUI, I-type whose rs2 field matches, load to x0.
    drive("load_rd7_b", mk(3'd2, 5'd1, 5'd0, 5'd7, 32'h4c, 1'b1, 1'b0, 1'b1), 1'b0);
    drive("lui_no_haz", mk(3'd7, 5'd7, 5'd7, 5'd9, 32'h50, 1'b0, 1'b0, 1'b1), 1'b0);
    drive("load_rd7_c", mk(3'd2, 5'd1, 5'd0, 5'd7, 32'h54, 1'b1, 1'b0, 1'b1), 1'b0);
    drive("itype_rs2f7", mk(3'd1, 5'd2, 5'd7, 5'd9, 32'h58, 1'b0, 1'b0, 1'b1), 1'b0);
    drive("load_rd0", mk(3'd2, 5'd1, 5'd0, 5'd0, 32'h5c, 1'b1, 1'b0, 1'b1), 1'b0);
    drive("use_x0", mk(3'd0, 5'd0, 5'd0, 5'd3, 32'h60, 1'b0, 1'b0, 1'b1), 1'b0);
    // Flush of a store, then flush coinciding with a load-use hazard.
    drive("flush_store", mk(3'd4, 5'd1, 5'd2, 5'd0, 32'h64, 1'b0, 1'b1, 1'b0), 1'b1);
    drive("load_rd6", mk(3'd2, 5'd1, 5'd0, 5'd6, 32'h68, 1'b1, 1'b0, 1'b1), 1'b0);
    drive("flush_haz", mk(3'd0, 5'd6, 5'd1, 5'd2, 32'h6c, 1'b0, 1'b0, 1'b1), 1'b1);

    // Reset mid-stall: outputs must clear without a clock edge.
    drive("load_rd7_d", mk(3'd2, 5'd1, 5'd0, 5'd7, 32'h70, 1'b1, 1'b0, 1'b1), 1'b0);
    t = mk(3'd0, 5'd7, 5'd1, 5'd4, 32'h74, 1'b0, 1'b0, 1'b1);
    {jalr_i, branch_i, mem_read_i, mem_to_reg_i, mem_write_i, alu_src_i, reg_write_i,
     alu_op_i, pc_i, rs1_data_i, rs2_data_i, imm_i, rs1_i, rs2_i, rd_i, funct_i} = t;
    flush_i = 1'b0;
    #1;
    check("pre_reset_stall", 157'(stall_o), 157'(1));
    reset = 1'b0;
    #1;
    check("midstall_reset_outputs", 157'(dut_out()), 157'(0));
    check("midstall_reset_stall", 157'(stall_o), 157'(0));
    model_ex = '0;
    @(negedge clk);
    reset = 1'b1;
    drive("post_reset_capture", t, 1'b0);

    // Randomized traffic; upstream holds the ID instruction while stalled.
    held = 1'b0;
    for (int i = 0; i < 400; i++) begin
      fl = ($urandom_range(0, 7) == 0);
      t = held ? prev : rand_txn();
      held = stall_q[$];
      drive("random", t, fl);
      prev = t;
      held = stall_q.size() > 0 ? stall_q[$] : 1'b0;
    end

    repeat (3) @(negedge clk);
    if (out_q.size() != 0 || stall_q.size() != 0)
      check("scoreboard_drained", 157'(out_q.size() + stall_q.size()), 157'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
